operand_unpack: RTL and testbench

Downstream consumer of the row/column address generators. Accepts the 32-bit operand words returned from the operand buffer at the generated read addresses. Unpacks each word into one element per cycle according to precision (FP32/FP16/INT8/INT4) and presents the elements, right-aligned in a 32-bit lane, to the systolic array edge. Each word is held until all its lanes are emitted, which is exactly the "advance address every 1/2/4/8 elements" cadence the address generator assumes.

---
 rtl/tc_pkg.sv | 8 +
 rtl/lane_extract.sv | 31 +++
 rtl/operand_unpack.sv | 98 +++++++++
 tb/tb_operand_unpack.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/tc_pkg.sv
// tc_pkg: shared precision enum, word width and lanes-per-word helper
package tc_pkg;
  localparam int WORD_W = 32;
  typedef enum logic [1:0] {PREC_FP32, PREC_FP16, PREC_INT8, PREC_INT4} prec_e;
  function automatic logic [3:0] lanes_per_word(prec_e p);
    return 4'd1 << p;
  endfunction
endpackage

// File: rtl/lane_extract.sv
// lane_extract: selects lane idx of a packed word and extends it to 32 bits
//   word_i : packed 32-bit operand word
//   idx_i  : lane index, lane 0 in the least-significant bits
//   prec_i : precision, sets lane width 32/16/8/4
//   elem_o : right-aligned element; INT8/INT4 sign-extended when SIGN_EXT_EN is defined, otherwise zero-extended
module lane_extract
  import tc_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [2:0]  idx_i,
  input  prec_e       prec_i,
  output logic [31:0] elem_o
);
`ifdef SIGN_EXT_EN
  localparam bit SX = 1'b1;
`else
  localparam bit SX = 1'b0;
`endif
  logic [4:0]  sh;
  logic [31:0] s;
  always_comb begin
    sh = prec_i == PREC_FP16 ? {idx_i[0], 4'b0} :
         prec_i == PREC_INT8 ? {idx_i[1:0], 3'b0} :
         prec_i == PREC_INT4 ? {idx_i, 2'b0} : 5'd0;
    s = word_i >> sh;
    elem_o = prec_i == PREC_FP32 ? s :
             prec_i == PREC_FP16 ? {16'b0, s[15:0]} :
             prec_i == PREC_INT8 ? {{24{SX & s[7]}}, s[7:0]} :
                                   {{28{SX & s[3]}}, s[3:0]};
  end
endmodule

// File: rtl/operand_unpack.sv
// operand_unpack: unpacks 32-bit operand words into one element per cycle by precision
//   clk, rst   : clock; synchronous active-low reset
//   start/mode/len : begin a tile (sampled in IDLE only)
//   word_*     : operand word input stream (valid/ready)
//   elem_*     : element output stream (valid/ready) with elem_last on the final element
//   busy, done : not-IDLE flag; one-cycle completion pulse
//   Build option SIGN_EXT_EN: sign-extend INT8/INT4 elements (see lane_extract).
module operand_unpack #(
  parameter int WORD_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [LEN_W-1:0]  len,
  input  logic              word_valid,
  output logic              word_ready,
  input  logic [WORD_W-1:0] word_data,
  output logic              elem_valid,
  input  logic              elem_ready,
  output logic [31:0]       elem_data,
  output logic              elem_last,
  output logic              busy,
  output logic              done
);
  import tc_pkg::*;
  typedef enum logic [1:0] {IDLE, FETCH, EMIT, DONE} state_e;
  state_e            state_q, state_d;
  prec_e             mode_q, mode_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [2:0]        idx_q, idx_d;
  logic [WORD_W-1:0] hold_q, hold_d;
  logic [31:0]       ext;
  logic              last_lane;
  lane_extract u_lane (.word_i(hold_q), .idx_i(idx_q), .prec_i(mode_q), .elem_o(ext));
  assign last_lane  = idx_q == 3'(lanes_per_word(mode_q) - 4'd1);
  assign elem_valid = state_q == EMIT;
  assign elem_last  = elem_valid && rem_q == LEN_W'(1);
  assign elem_data  = elem_valid ? ext : '0;
  assign busy       = state_q != IDLE;
  assign done       = state_q == DONE;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      mode_q  <= PREC_FP32;
      rem_q   <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
    end
  end
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    rem_d      = rem_q;
    idx_d      = idx_q;
    hold_d     = hold_q;
    word_ready = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        if (len != '0) begin
          mode_d  = prec_e'(mode);
          rem_d   = len;
          idx_d   = '0;
          state_d = FETCH;
        end else state_d = DONE;
      end
      FETCH: begin
        word_ready = 1'b1;
        if (word_valid) begin
          hold_d  = word_data;
          idx_d   = '0;
          state_d = EMIT;
        end
      end
      EMIT: if (elem_ready) begin
        rem_d = rem_q - LEN_W'(1);
        idx_d = idx_q + 3'd1;
        if (rem_q == LEN_W'(1)) state_d = DONE;
        else if (last_lane) begin
          // overlapped fetch: take the next word in the same cycle the last lane leaves
          word_ready = 1'b1;
          idx_d      = '0;
          if (word_valid) hold_d = word_data;
          else state_d = FETCH;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_operand_unpack.sv
// tb_operand_unpack: directed self-checking bench for operand_unpack
module tb_operand_unpack;
  logic        clk = 0, rst = 0, start = 0, word_valid = 0, elem_ready = 0;
  logic [1:0]  mode = 0;
  logic [15:0] len = 0;
  logic [31:0] word_data = 0;
  logic        word_ready, elem_valid, elem_last, busy, done;
  logic [31:0] elem_data;
  int checks = 0, errors = 0;
  logic [31:0] src_q[$], exp_q[$];
  operand_unpack dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .len(len),
    .word_valid(word_valid), .word_ready(word_ready), .word_data(word_data),
    .elem_valid(elem_valid), .elem_ready(elem_ready), .elem_data(elem_data),
    .elem_last(elem_last), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_word_ready"}, word_ready, 0);
    chk({tag, "_elem_valid"}, elem_valid, 0);
    chk({tag, "_elem_data"}, elem_data, 0);
    chk({tag, "_elem_last"}, elem_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask
  task automatic run_tile(input logic [1:0] m, input int n, input int nwords, input logic [3:0] pat, input bit gapless);
    int lanes = 1 << m;
    int last_hs = 0, first_hs = -1, words = 0, got = 0, rem = n;
    bit seen = 0, stalled = 0;
    logic [31:0] pd;
    logic pl;
    @(negedge clk);
    start = 1; mode = m; len = 16'(n); word_valid = 0; elem_ready = 0;
    @(negedge clk);
    start = 0;
    for (int c = 1; c < 200 && !seen; c++) begin
      if (c > 1) @(negedge clk);
      word_valid = src_q.size() > 0;
      word_data  = word_valid ? src_q[0] : 32'h0;
      elem_ready = pat[c % 4];
      #1;
      if (c == 1) chk("ready_after_start", word_ready, n != 0);
      if (stalled) begin
        chk("stall_data", elem_data, pd);
        chk("stall_last", elem_last, pl);
      end
      stalled = elem_valid && !elem_ready;
      pd = elem_data;
      pl = elem_last;
      if (elem_valid && elem_ready) begin
        if (exp_q.size() == 0) chk("extra_elem", got + 1, n);
        else chk("elem_data", elem_data, exp_q.pop_front());
        chk("elem_last", elem_last, rem == 1);
        if (got % lanes == lanes - 1 && rem > 1) chk("overlap_ready", word_ready, 1);
        if (first_hs < 0) first_hs = c;
        last_hs = c;
        got++;
        rem--;
      end
      if (word_valid && word_ready) begin
        void'(src_q.pop_front());
        words++;
      end
      if (done) begin
        seen = 1;
        chk("done_cycle", c, last_hs + 1);
      end
    end
    chk("done_seen", seen, 1);
    chk("words", words, nwords);
    chk("elems", got, n);
    if (gapless && n > 0) chk("gapless", last_hs - first_hs, n - 1);
    word_valid = 0;
    @(negedge clk);
    #1;
    chk("done_pulse", done, 0);
    chk("idle_busy", busy, 0);
    src_q.delete();
    exp_q.delete();
  endtask
  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1;
    src_q = '{32'h11111111, 32'h22222222, 32'h33333333};
    exp_q = '{32'h11111111, 32'h22222222, 32'h33333333};
    run_tile(2'd0, 3, 3, 4'hF, 1);
    src_q = '{32'hBBBBAAAA, 32'hDDDDCCCC};
    exp_q = '{32'h0000AAAA, 32'h0000BBBB, 32'h0000CCCC, 32'h0000DDDD};
    run_tile(2'd1, 4, 2, 4'hF, 1);
    src_q = '{32'h87654321};
    exp_q = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5};
    run_tile(2'd3, 5, 1, 4'hF, 1);
    src_q = '{32'h000000F8};
`ifdef SIGN_EXT_EN
    exp_q = '{32'hFFFFFFF8, 32'hFFFFFFFF};
`else
    exp_q = '{32'h00000008, 32'h0000000F};
`endif
    run_tile(2'd3, 2, 1, 4'hF, 1);
    src_q = '{32'h807F0201};
`ifdef SIGN_EXT_EN
    exp_q = '{32'h01, 32'h02, 32'h7F, 32'hFFFFFF80};
`else
    exp_q = '{32'h01, 32'h02, 32'h7F, 32'h80};
`endif
    run_tile(2'd2, 4, 1, 4'b0011, 0);
    run_tile(2'd0, 0, 0, 4'hF, 0);
    @(negedge clk);
    start = 1; mode = 2'd1; len = 16'd4;
    @(negedge clk);
    start = 0; word_valid = 1; word_data = 32'h22221111; elem_ready = 1;
    @(negedge clk);
    word_valid = 0;
    #1;
    chk("mid_valid", elem_valid, 1);
    chk("mid_data", elem_data, 32'h00001111);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    #1;
    chk_reset_outputs("midreset");
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("post_reset_done", done, 0);
      chk("post_reset_busy", busy, 0);
    end
    src_q = '{32'h00020001, 32'h00040003};
    exp_q = '{32'h1, 32'h2, 32'h3};
    run_tile(2'd1, 3, 2, 4'hF, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
